graph_mem_server: RTL and testbench

Responder side of the graph fetch memory protocol. Accepts word-read requests on two independent request channels, ch0 for row-index lookups and ch1 for neighbour/vertex data, from the graph fetch engine. It serialises them onto one internal single-ported block RAM holding the CSR graph image, and returns each word on the matching response channel. A host write port loads the graph image before traversal starts.

---
 rtl/graph_mem_pkg.sv | 26 ++
 rtl/graph_bram.sv | 36 +++
 rtl/graph_req_fifo.sv | 68 ++++++
 rtl/graph_mem_server.sv | 144 ++++++++++++++
 tb/tb_graph_mem_server.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/graph_mem_pkg.sv
// Shared definitions for the graph fetch memory protocol.
// Holds the request channel enum, the request payload struct and the
// default address/data widths used by graph_fetch and graph_mem_server.
package graph_mem_pkg;

  localparam int unsigned GM_ADDR_W = 10;
  localparam int unsigned GM_DATA_W = 32;
  localparam int unsigned NUM_CH    = 2;

  // ch0 carries row-index lookups, ch1 neighbour/vertex data
  typedef enum logic {
    CH_ROW  = 1'b0,
    CH_DATA = 1'b1
  } chan_e;

  typedef struct packed {
    logic [GM_ADDR_W-1:0] addr;
    chan_e                chan;
  } req_t;

  // One-hot per-channel strobe for a channel tag
  function automatic logic [NUM_CH-1:0] chan_onehot(input chan_e c);
    return (c == CH_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/graph_bram.sv
// Inferred single-port block RAM holding the CSR graph image.
// Ports: clk; we/re with a shared addr; wdata; rdata valid READ_LAT cycles
// after a read access. Contents are not reset.
module graph_bram #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned READ_LAT = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] rd_q [READ_LAT];

  // Array access plus output register chain
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rd_q[0] <= mem[addr];
    end
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      rd_q[i] <= rd_q[i-1];
    end
  end

  assign rdata = rd_q[READ_LAT-1];

endmodule

// File: rtl/graph_req_fifo.sv
// Synchronous request address FIFO, one per request channel.
// Ports: clk/rst_n; push+din write side; pop+dout (show-ahead) read side;
// full/empty flags and count are registered so ready never depends on
// same-cycle pop.
module graph_req_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_nxt;

  // Next occupancy from this cycle's push/pop
  always_comb begin
    cnt_nxt = count;
    if (push && !pop) begin
      cnt_nxt = count + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_nxt = count - CNT_W'(1);
    end
  end

  // Pointers and flags; pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= cnt_nxt;
      full  <= (cnt_nxt == CNT_W'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/graph_mem_server.sv
// Responder for the graph fetch memory protocol.
// Two request channels (ch0 row-index, ch1 neighbour/vertex data) are queued
// and serialised onto one single-port BRAM; each word returns on the
// channel that asked for it. A host write port loads the graph image and
// always wins the BRAM port.
// Ports: clk_in/rst_in; req_valid_in/req_addr_in/req_ready_out per channel;
// resp_valid_out/resp_data_out per channel; wr_en_in/wr_addr_in/wr_data_in
// host write; busy_out while anything is queued or in flight.
module graph_mem_server
  import graph_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = GM_ADDR_W,
  parameter int unsigned DATA_W   = GM_DATA_W,
  parameter int unsigned READ_LAT = 2,
  parameter int unsigned QDEPTH   = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [1:0]             req_valid_in,
  input  logic [1:0][ADDR_W-1:0] req_addr_in,
  output logic [1:0]             req_ready_out,
  output logic [1:0]             resp_valid_out,
  output logic [1:0][DATA_W-1:0] resp_data_out,
  input  logic                   wr_en_in,
  input  logic [ADDR_W-1:0]      wr_addr_in,
  input  logic [DATA_W-1:0]      wr_data_in,
  output logic                   busy_out
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             full;
  logic [1:0]             empty;
  logic [1:0][ADDR_W-1:0] q_addr;
  logic [1:0][CNT_W-1:0]  q_count;

  chan_e                  last_grant;
  chan_e                  grant;
  logic                   issue;

  // BRAM port register: holds either the host write or the granted read
  logic                   port_we;
  logic [ADDR_W-1:0]      port_addr;
  logic [DATA_W-1:0]      port_wdata;
  logic [DATA_W-1:0]      rdata;

  // Stage 0 is the port register; stage READ_LAT lines up with rdata
  logic [READ_LAT:0]      pipe_vld;
  chan_e                  pipe_tag [READ_LAT+1];

  assign req_ready_out = ~full;
  assign push          = req_valid_in & req_ready_out;

  for (genvar c = 0; c < 2; c++) begin : g_q
    graph_req_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (QDEPTH)
    ) u_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .push  (push[c]),
      .din   (req_addr_in[c]),
      .pop   (pop[c]),
      .dout  (q_addr[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (q_count[c])
    );
  end

  // Round-robin read grant; a host write takes the port for the cycle
  always_comb begin
    grant = CH_ROW;
    issue = 1'b0;
    pop   = '0;
    if (!wr_en_in && (!empty[0] || !empty[1])) begin
      issue = 1'b1;
      if (!empty[0] && !empty[1]) begin
        grant = (last_grant == CH_ROW) ? CH_DATA : CH_ROW;
      end else if (empty[0]) begin
        grant = CH_DATA;
      end
      pop = chan_onehot(grant);
    end
  end

  // Arbiter state, port register and tag pipeline
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant <= CH_DATA;
      port_we    <= 1'b0;
      port_addr  <= '0;
      port_wdata <= '0;
      pipe_vld   <= '0;
      for (int unsigned i = 0; i <= READ_LAT; i++) begin
        pipe_tag[i] <= CH_ROW;
      end
    end else begin
      port_we    <= wr_en_in;
      port_addr  <= wr_en_in ? wr_addr_in : q_addr[grant];
      port_wdata <= wr_data_in;
      if (issue) begin
        last_grant <= grant;
      end
      pipe_vld    <= {pipe_vld[READ_LAT-1:0], issue};
      pipe_tag[0] <= grant;
      for (int unsigned i = 1; i <= READ_LAT; i++) begin
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  graph_bram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_bram (
    .clk   (clk_in),
    .we    (port_we),
    .re    (pipe_vld[0]),
    .addr  (port_addr),
    .wdata (port_wdata),
    .rdata (rdata)
  );

  // Response register; the idle channel keeps its last data
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      resp_valid_out <= '0;
      resp_data_out  <= '0;
    end else begin
      resp_valid_out <= '0;
      if (pipe_vld[READ_LAT]) begin
        resp_valid_out                  <= chan_onehot(pipe_tag[READ_LAT]);
        resp_data_out[pipe_tag[READ_LAT]] <= rdata;
      end
    end
  end

  assign busy_out = (|q_count[0]) | (|q_count[1]) | (|pipe_vld);

endmodule

// File: tb/tb_graph_mem_server.sv
// Directed bench for graph_mem_server with a per-channel response scoreboard.
module tb_graph_mem_server;
  import graph_mem_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic                   clk_in = 1'b0;
  logic                   rst_in;
  logic [1:0]             req_valid_in;
  logic [1:0][ADDR_W-1:0] req_addr_in;
  logic [1:0]             req_ready_out;
  logic [1:0]             resp_valid_out;
  logic [1:0][DATA_W-1:0] resp_data_out;
  logic                   wr_en_in;
  logic [ADDR_W-1:0]      wr_addr_in;
  logic [DATA_W-1:0]      wr_data_in;
  logic                   busy_out;

  graph_mem_server #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .READ_LAT (2),
    .QDEPTH   (4)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .req_valid_in   (req_valid_in),
    .req_addr_in    (req_addr_in),
    .req_ready_out  (req_ready_out),
    .resp_valid_out (resp_valid_out),
    .resp_data_out  (resp_data_out),
    .wr_en_in       (wr_en_in),
    .wr_addr_in     (wr_addr_in),
    .wr_data_in     (wr_data_in),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  logic [DATA_W-1:0] mem_model [1024];
  logic [DATA_W-1:0] exp0 [$];
  logic [DATA_W-1:0] exp1 [$];
  logic [DATA_W-1:0] rx0_d [$];
  logic [DATA_W-1:0] rx1_d [$];
  int                rx0_c [$];
  int                rx1_c [$];
  int                order [$];

  always @(posedge clk_in) cyc <= cyc + 1;

  // Capture every response pulse away from the clock edge
  always @(negedge clk_in) begin
    if (resp_valid_out[0]) begin
      rx0_d.push_back(resp_data_out[0]);
      rx0_c.push_back(cyc);
      order.push_back(0);
    end
    if (resp_valid_out[1]) begin
      rx1_d.push_back(resp_data_out[1]);
      rx1_c.push_back(cyc);
      order.push_back(1);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input int addr, input logic [DATA_W-1:0] data);
    wr_en_in   = 1'b1;
    wr_addr_in = ADDR_W'(addr);
    wr_data_in = data;
    @(posedge clk_in);
    mem_model[addr] = data;
    #1;
    wr_en_in = 1'b0;
  endtask

  // Present one request and wait (bounded) for it to be accepted
  task automatic send(input int ch, input int addr, input bit track, output int t_acc);
    bit ok;
    ok    = 1'b0;
    t_acc = -1;
    req_valid_in[ch] = 1'b1;
    req_addr_in[ch]  = ADDR_W'(addr);
    for (int w = 0; w < 400 && !ok; w++) begin
      @(negedge clk_in);
      ok = req_ready_out[ch];
      @(posedge clk_in);
      #1;
    end
    req_valid_in[ch] = 1'b0;
    check($sformatf("accept_ch%0d", ch), 64'(ok), 64'd1);
    if (ok) begin
      t_acc = cyc;
      if (track) begin
        if (ch == 0) exp0.push_back(mem_model[addr]);
        else         exp1.push_back(mem_model[addr]);
      end
    end
  endtask

  // Wait for all expected responses on a channel, then compare in order
  task automatic drain(input int ch, input string tag, output int first_cyc);
    int n_exp;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] e;
    int c;
    n_exp     = (ch == 0) ? exp0.size() : exp1.size();
    first_cyc = -1;
    for (int w = 0; w < 6000; w++) begin
      if (((ch == 0) ? rx0_d.size() : rx1_d.size()) >= n_exp) break;
      @(posedge clk_in);
      #1;
    end
    check($sformatf("%s_count", tag), 64'((ch == 0) ? rx0_d.size() : rx1_d.size()), 64'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (((ch == 0) ? rx0_d.size() : rx1_d.size()) == 0) break;
      if (ch == 0) begin
        d = rx0_d.pop_front(); c = rx0_c.pop_front(); e = exp0.pop_front();
      end else begin
        d = rx1_d.pop_front(); c = rx1_c.pop_front(); e = exp1.pop_front();
      end
      if (i == 0) first_cyc = c;
      check($sformatf("%s_data%0d", tag, i), 64'(d), 64'(e));
    end
    if (ch == 0) exp0.delete();
    else         exp1.delete();
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t_acc;
    int  t_first;
    int  first;
    int  n_acc;
    bit  acc;
    bit  s_done;

    rst_in       = 1'b0;
    req_valid_in = '0;
    req_addr_in  = '0;
    wr_en_in     = 1'b0;
    wr_addr_in   = '0;
    wr_data_in   = '0;
    s_done       = 1'b0;

    // Reset values
    repeat (3) @(posedge clk_in);
    #1;
    check("rst_ready", 64'(req_ready_out), 64'h3);
    check("rst_resp_valid", 64'(resp_valid_out), 64'h0);
    check("rst_resp_data", 64'(resp_data_out), 64'h0);
    check("rst_busy", 64'(busy_out), 64'h0);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Load the graph image
    for (int a = 0; a < 64; a++) host_write(a, DATA_W'(32'h1000 + a));

    // Single ch0 read: 4-cycle latency, ch1 idle
    send(0, 5, 1'b1, t_acc);
    drain(0, "t1", first);
    check("t1_latency", 64'(first - t_acc), 64'd4);
    check("t1_ch1_idle_count", 64'(rx1_d.size()), 64'd0);
    check("t1_ch1_idle_data", 64'(resp_data_out[1]), 64'h0);

    // Both channels saturated: strict alternation, ch1 first (ch0 won last)
    order.delete();
    fork
      begin
        int ta;
        for (int i = 0; i < 8; i++) send(0, i, 1'b1, ta);
      end
      begin
        int tb;
        for (int i = 8; i < 16; i++) send(1, i, 1'b1, tb);
      end
    join
    drain(0, "t2_ch0", first);
    drain(1, "t2_ch1", first);
    check("t2_order_len", 64'(order.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < order.size()) check($sformatf("t2_order%0d", i), 64'(order[i]), (i % 2 == 0) ? 64'd1 : 64'd0);
    end

    // ch1 burst against 6 write cycles: queue fills, reads wait out the writes
    wr_en_in         = 1'b1;
    wr_addr_in       = ADDR_W'(64);
    wr_data_in       = 32'hB040;
    req_valid_in[1]  = 1'b1;
    req_addr_in[1]   = ADDR_W'(20);
    n_acc            = 0;
    t_first          = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      acc = req_valid_in[1] & req_ready_out[1];
      @(posedge clk_in);
      mem_model[wr_addr_in] = wr_data_in;
      #1;
      if (acc) begin
        exp1.push_back(mem_model[20 + n_acc]);
        if (n_acc == 0) t_first = cyc;
        n_acc++;
        req_addr_in[1] = ADDR_W'(20 + n_acc);
      end
      if (k == 3) begin
        check("t3_acc_before_full", 64'(n_acc), 64'd4);
        check("t3_ready_low", 64'(req_ready_out[1]), 64'd0);
      end
      if (k < 5) begin
        wr_addr_in = wr_addr_in + ADDR_W'(1);
        wr_data_in = 32'hB000 + 32'(wr_addr_in);
      end else begin
        wr_en_in = 1'b0;
      end
    end
    check("t3_acc_during_writes", 64'(n_acc), 64'd4);
    req_valid_in[1] = 1'b0;
    send(1, 24, 1'b1, t_acc);
    drain(1, "t3", first);
    check("t3_first_latency", 64'(first - t_first), 64'd9);

    // Write then read next cycle returns the new word
    host_write(3, 32'hDEAD);
    send(0, 3, 1'b0, t_acc);
    exp0.push_back(32'hDEAD);
    drain(0, "t4", first);

    // Reset with requests in flight drops them
    send(0, 1, 1'b0, t_acc);
    send(0, 2, 1'b0, t_acc);
    send(1, 9, 1'b0, t_acc);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    check("t5_busy_after_rst", 64'(busy_out), 64'd0);
    check("t5_ready_after_rst", 64'(req_ready_out), 64'h3);
    repeat (8) @(posedge clk_in);
    #1;
    check("t5_no_resp_ch0", 64'(rx0_d.size()), 64'd0);
    check("t5_no_resp_ch1", 64'(rx1_d.size()), 64'd0);
    send(0, 7, 1'b0, t_acc);
    exp0.push_back(32'h1007);
    drain(0, "t5", first);
    check("t5_latency", 64'(first - t_acc), 64'd4);

    // Random stress: 1000 reads per channel, writes interleaved elsewhere
    fork
      begin
        fork
          begin
            int gap;
            int ta;
            for (int i = 0; i < 1000; i++) begin
              gap = int'($urandom_range(0, 2));
              for (int g = 0; g < gap; g++) begin @(posedge clk_in); #1; end
              send(0, int'($urandom_range(0, 63)), 1'b1, ta);
            end
          end
          begin
            int gap;
            int tb;
            for (int i = 0; i < 1000; i++) begin
              gap = int'($urandom_range(0, 2));
              for (int g = 0; g < gap; g++) begin @(posedge clk_in); #1; end
              send(1, int'($urandom_range(0, 63)), 1'b1, tb);
            end
          end
        join
        s_done = 1'b1;
      end
      begin
        for (int w = 0; w < 40000 && !s_done; w++) begin
          wr_en_in   = ($urandom_range(0, 4) == 0);
          wr_addr_in = ADDR_W'(64 + $urandom_range(0, 63));
          wr_data_in = $urandom;
          @(posedge clk_in);
          if (wr_en_in) mem_model[wr_addr_in] = wr_data_in;
          #1;
        end
        wr_en_in = 1'b0;
      end
    join
    drain(0, "stress_ch0", first);
    drain(1, "stress_ch1", first);
    repeat (20) @(posedge clk_in);
    #1;
    check("stress_no_dup_ch0", 64'(rx0_d.size()), 64'd0);
    check("stress_no_dup_ch1", 64'(rx1_d.size()), 64'd0);
    check("stress_idle_busy", 64'(busy_out), 64'd0);

    // Read back some host-written words
    for (int a = 64; a < 68; a++) send(1, a, 1'b1, t_acc);
    drain(1, "readback", first);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
